// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - hz_state_t : sequencer state (RUN / MEMWAIT / FLUSH)
//   - OP_*       : opcode constants of the five-stage core
//   - uses_rt()  : true when an opcode actually reads its rt operand, so
//                  hazard detection and forwarding logic agree on it
// ----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } hz_state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLT   = 6'h06;
    localparam logic [5:0] OP_BLE   = 6'h07;
    localparam logic [5:0] OP_ALUI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALU-immediate and load forms carry a destination in the rt field,
    // so only these opcodes genuinely read rt as a source.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BLT) ||
               (op == OP_BLE)   || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/hz_wait_timer.sv
// ----------------------------------------------------------------------------
// hz_wait_timer
// Loadable down-counter shared by the flush sequencer and the memory-wait
// timeout. Saturates at zero.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (count -> 0)
//   load        : load load_value (has priority over dec)
//   load_value  : value to load
//   dec         : decrement by one when non-zero
//   zero        : count == 0
//   last        : count == 1 (the next decrement reaches zero)
// ----------------------------------------------------------------------------
module hz_wait_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero,
    output logic             last
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);
    assign last = (count == WIDTH'(1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer of the five-stage core. Detects load-use
// hazards, holds the pipe during data-memory waits and flushes the front end
// on taken branches / JAL, redirecting fetch.
// Ports:
//   i_clk, i_reset_n              : clock, asynchronous active-low reset
//   decode_op/rs/rt               : instruction leaving decode
//   ex_valid/ex_is_load/ex_rd     : instruction in execute
//   br_redirect, br_target        : branch resolution from execute
//   mem_req, mem_ready            : data-memory handshake
//   rr_stall, rr_flush            : register-read stall / flush
//   ex_stall, ex_bubble           : freeze execute+memory / bubble execute
//   fetch_redirect(_pc)           : one-cycle fetch redirect and its target
//   mem_timeout                   : sticky memory-wait timeout flag
//   perf_stall_cycles/flush_events: performance counters
// Parameters: FLUSH_CYCLES (1..15), MEM_TIMEOUT (1..1023).
// Optional feature macro: HAZARD_PERF_CNT_EN enables the performance
// counters; without it both counter outputs are tied to zero.
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [5:0]  decode_op,
    input  logic [3:0]  decode_rs,
    input  logic [3:0]  decode_rt,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic [3:0]  ex_rd,
    input  logic        br_redirect,
    input  logic [31:0] br_target,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        rr_stall,
    output logic        rr_flush,
    output logic        ex_stall,
    output logic        ex_bubble,
    output logic        fetch_redirect,
    output logic [31:0] fetch_redirect_pc,
    output logic        mem_timeout,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_events
);

    // A redirect issued straight from RUN/FLUSH already spends one flush
    // cycle in that same cycle; one deferred from MEMWAIT spends all of them
    // inside FLUSH.
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] FLUSH_FULL   = 4'(FLUSH_CYCLES);
    localparam logic [9:0] MEM_LIMIT    = 10'(MEM_TIMEOUT);

    hz_state_t   state;
    hz_state_t   next_state;
    logic        pending;
    logic [31:0] target_q;

    logic        load_use;
    logic        rs_used;
    logic        rt_used;
    logic        direct_redirect;
    logic        latch_redirect;
    logic        clear_pending;
    logic        flush_load;
    logic [3:0]  flush_load_value;
    logic        flush_dec;
    logic        flush_zero;
    logic        flush_last;
    logic        mem_load;
    logic        mem_dec;
    logic        mem_zero;
    logic        mem_last;

    assign rs_used  = (decode_rs != 4'd0);
    assign rt_used  = (decode_rt != 4'd0) && uses_rt(decode_op);
    assign load_use = ex_valid && ex_is_load && (ex_rd != 4'd0) &&
                      ((rs_used && (ex_rd == decode_rs)) ||
                       (rt_used && (ex_rd == decode_rt)));

    hz_wait_timer #(.WIDTH(4)) u_flush_timer (
        .clk        (i_clk),
        .rst_n      (i_reset_n),
        .load       (flush_load),
        .load_value (flush_load_value),
        .dec        (flush_dec),
        .zero       (flush_zero),
        .last       (flush_last)
    );

    hz_wait_timer #(.WIDTH(10)) u_mem_timer (
        .clk        (i_clk),
        .rst_n      (i_reset_n),
        .load       (mem_load),
        .load_value (MEM_LIMIT),
        .dec        (mem_dec),
        .zero       (mem_zero),
        .last       (mem_last)
    );

    // Control outputs and next-state decisions. Load-use is only examined in
    // the final RUN branch, which is never reached while rr_flush is high.
    always_comb begin
        rr_stall         = 1'b0;
        rr_flush         = 1'b0;
        ex_stall         = 1'b0;
        ex_bubble        = 1'b0;
        fetch_redirect   = 1'b0;
        direct_redirect  = 1'b0;
        latch_redirect   = 1'b0;
        clear_pending    = 1'b0;
        flush_load       = 1'b0;
        flush_load_value = FLUSH_RELOAD;
        flush_dec        = 1'b0;
        mem_load         = 1'b0;
        mem_dec          = 1'b0;
        next_state       = state;
        unique case (state)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    rr_stall       = 1'b1;
                    ex_stall       = 1'b1;
                    mem_load       = 1'b1;
                    // A redirect coinciding with the stall is deferred, not lost.
                    latch_redirect = br_redirect;
                    next_state     = ST_MEMWAIT;
                end else if (br_redirect) begin
                    fetch_redirect  = 1'b1;
                    direct_redirect = 1'b1;
                    rr_flush        = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        flush_load = 1'b1;
                        next_state = ST_FLUSH;
                    end
                end else if (load_use) begin
                    rr_stall  = 1'b1;
                    ex_bubble = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                rr_stall       = 1'b1;
                ex_stall       = 1'b1;
                mem_dec        = 1'b1;
                latch_redirect = br_redirect;
                if (mem_ready) begin
                    if (pending || br_redirect) begin
                        flush_load       = 1'b1;
                        flush_load_value = FLUSH_FULL;
                        next_state       = ST_FLUSH;
                    end else begin
                        next_state = ST_RUN;
                    end
                end
            end
            ST_FLUSH: begin
                rr_flush  = 1'b1;
                ex_bubble = 1'b1;
                if (br_redirect) begin
                    // A newer redirect supersedes any deferred one.
                    fetch_redirect  = 1'b1;
                    direct_redirect = 1'b1;
                    clear_pending   = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        flush_load = 1'b1;
                    end else begin
                        next_state = ST_RUN;
                    end
                end else begin
                    if (pending) begin
                        fetch_redirect = 1'b1;
                        clear_pending  = 1'b1;
                    end
                    flush_dec = 1'b1;
                    if (flush_last || flush_zero) begin
                        next_state = ST_RUN;
                    end
                end
            end
            default: next_state = ST_RUN;
        endcase
    end

    // The target register tracks the latest redirect; a direct redirect
    // presents br_target combinationally in its own cycle.
    assign fetch_redirect_pc = direct_redirect ? br_target : target_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_RUN;
            pending     <= 1'b0;
            target_q    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= next_state;
            if (latch_redirect) begin
                pending  <= 1'b1;
                target_q <= br_target;
            end else begin
                if (clear_pending) begin
                    pending <= 1'b0;
                end
                if (direct_redirect) begin
                    target_q <= br_target;
                end
            end
            if ((state == ST_MEMWAIT) && (mem_last || mem_zero)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (rr_stall) begin
                stall_count <= stall_count + 32'd1;
            end
            if (fetch_redirect) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = stall_count;
    assign perf_flush_events = flush_count;
`else
    assign perf_stall_cycles = '0;
    assign perf_flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Scoreboard bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=8).
// Each stimulus cycle pushes its expected control outputs; a negedge monitor
// pops and compares them. Build with or without HAZARD_PERF_CNT_EN.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    // Expected control vector: {rr_stall, rr_flush, ex_stall, ex_bubble,
    // fetch_redirect, mem_timeout}
    localparam logic [5:0] E_NONE  = 6'b000000;
    localparam logic [5:0] E_LU    = 6'b100100;
    localparam logic [5:0] E_RDIR  = 6'b010010;
    localparam logic [5:0] E_FLUSH = 6'b010100;
    localparam logic [5:0] E_FPULS = 6'b010110;
    localparam logic [5:0] E_MEM   = 6'b101000;
    localparam logic [5:0] E_MEMTO = 6'b101001;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [31:0] EXP_STALLS  = 32'd3;
    localparam logic [31:0] EXP_FLUSHES = 32'd2;
`else
    localparam logic [31:0] EXP_STALLS  = 32'd0;
    localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

    typedef struct {
        string       tag;
        logic [5:0]  ctl;
        logic [31:0] pc;
    } sb_entry_t;

    logic        clk;
    logic        reset_n;
    logic [5:0]  decode_op;
    logic [3:0]  decode_rs;
    logic [3:0]  decode_rt;
    logic        ex_valid;
    logic        ex_is_load;
    logic [3:0]  ex_rd;
    logic        br_redirect;
    logic [31:0] br_target;
    logic        mem_req;
    logic        mem_ready;
    logic        rr_stall;
    logic        rr_flush;
    logic        ex_stall;
    logic        ex_bubble;
    logic        fetch_redirect;
    logic [31:0] fetch_redirect_pc;
    logic        mem_timeout;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_events;

    sb_entry_t sb_q[$];
    int vector_count = 0;
    int miss_count   = 0;

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES (2),
        .MEM_TIMEOUT  (8)
    ) dut (
        .i_clk             (clk),
        .i_reset_n         (reset_n),
        .decode_op         (decode_op),
        .decode_rs         (decode_rs),
        .decode_rt         (decode_rt),
        .ex_valid          (ex_valid),
        .ex_is_load        (ex_is_load),
        .ex_rd             (ex_rd),
        .br_redirect       (br_redirect),
        .br_target         (br_target),
        .mem_req           (mem_req),
        .mem_ready         (mem_ready),
        .rr_stall          (rr_stall),
        .rr_flush          (rr_flush),
        .ex_stall          (ex_stall),
        .ex_bubble         (ex_bubble),
        .fetch_redirect    (fetch_redirect),
        .fetch_redirect_pc (fetch_redirect_pc),
        .mem_timeout       (mem_timeout),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_events (perf_flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected for that cycle.
    task automatic applyStimulus(input string tag, input logic [5:0] op,
                                 input logic [3:0] rs, input logic [3:0] rt,
                                 input logic exv, input logic exl, input logic [3:0] exrd,
                                 input logic br, input logic [31:0] tgt,
                                 input logic mreq, input logic mrdy,
                                 input logic [5:0] exp_ctl, input logic [31:0] exp_pc);
        sb_entry_t ent;
        @(posedge clk);
        #1;
        decode_op   = op;
        decode_rs   = rs;
        decode_rt   = rt;
        ex_valid    = exv;
        ex_is_load  = exl;
        ex_rd       = exrd;
        br_redirect = br;
        br_target   = tgt;
        mem_req     = mreq;
        mem_ready   = mrdy;
        ent.tag = tag;
        ent.ctl = exp_ctl;
        ent.pc  = exp_pc;
        sb_q.push_back(ent);
    endtask

    task automatic idleCycle(input string tag, input logic [5:0] exp_ctl);
        applyStimulus(tag, OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0,
                      1'b0, 1'b0, exp_ctl, 32'h0);
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        decode_op   = OP_RTYPE;
        decode_rs   = 4'd0;
        decode_rt   = 4'd0;
        ex_valid    = 1'b0;
        ex_is_load  = 1'b0;
        ex_rd       = 4'd0;
        br_redirect = 1'b0;
        br_target   = 32'h0;
        mem_req     = 1'b0;
        mem_ready   = 1'b0;
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            sb_entry_t ent;
            ent = sb_q.pop_front();
            checkOutput(ent.tag,
                        {26'd0, rr_stall, rr_flush, ex_stall, ex_bubble, fetch_redirect, mem_timeout},
                        {26'd0, ent.ctl});
            if (ent.ctl[1]) begin
                checkOutput({ent.tag, "_pc"}, fetch_redirect_pc, ent.pc);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        decode_op   = OP_RTYPE;
        decode_rs   = 4'd0;
        decode_rt   = 4'd0;
        ex_valid    = 1'b0;
        ex_is_load  = 1'b0;
        ex_rd       = 4'd0;
        br_redirect = 1'b0;
        br_target   = 32'h0;
        mem_req     = 1'b0;
        mem_ready   = 1'b0;

        // Reset state
        idleCycle("reset_ctl", E_NONE);
        @(negedge clk);
        #1;
        checkOutput("reset_perf_stall", perf_stall_cycles, 32'd0);
        checkOutput("reset_perf_flush", perf_flush_events, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Load-use on rs, then the bubble leaves execute
        applyStimulus("lu_rs", OP_RTYPE, 4'd3, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 32'h0, 1'b0, 1'b0, E_LU, 32'h0);
        applyStimulus("lu_after", OP_RTYPE, 4'd3, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0, 1'b0, E_NONE, 32'h0);
        applyStimulus("lu_rd0", OP_RTYPE, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 32'h0, 1'b0, 1'b0, E_NONE, 32'h0);
        applyStimulus("lu_rd0_rs3", OP_RTYPE, 4'd3, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 32'h0, 1'b0, 1'b0, E_NONE, 32'h0);
        // rt usage depends on opcode
        applyStimulus("lu_sw_rt", OP_SW, 4'd1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b0, 32'h0, 1'b0, 1'b0, E_LU, 32'h0);
        applyStimulus("lu_alui_rt", OP_ALUI, 4'd1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b0, 32'h0, 1'b0, 1'b0, E_NONE, 32'h0);
        applyStimulus("lu_beq_rt", OP_BEQ, 4'd1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b0, 32'h0, 1'b0, 1'b0, E_LU, 32'h0);
        applyStimulus("lu_not_load", OP_BEQ, 4'd1, 4'd5, 1'b1, 1'b0, 4'd5, 1'b0, 32'h0, 1'b0, 1'b0, E_NONE, 32'h0);
        applyStimulus("lu_not_valid", OP_BEQ, 4'd1, 4'd5, 1'b0, 1'b1, 4'd5, 1'b0, 32'h0, 1'b0, 1'b0, E_NONE, 32'h0);

        // Redirect with a hazard held during the flush
        applyStimulus("rd_pulse", OP_RTYPE, 4'd3, 4'd0, 1'b1, 1'b1, 4'd3, 1'b1, 32'h100, 1'b0, 1'b0, E_RDIR, 32'h100);
        applyStimulus("rd_flush2", OP_RTYPE, 4'd3, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 32'h0, 1'b0, 1'b0, E_FLUSH, 32'h0);
        idleCycle("rd_done", E_NONE);

        // Back-to-back redirects reload the flush; mem_req ignored in FLUSH
        applyStimulus("rr_first", OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 32'h200, 1'b0, 1'b0, E_RDIR, 32'h200);
        applyStimulus("rr_second", OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 32'h300, 1'b0, 1'b0, E_FPULS, 32'h300);
        applyStimulus("rr_memign", OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 1'b0, E_FLUSH, 32'h0);
        idleCycle("rr_done", E_NONE);

        // Memory handshakes: immediate ready, then one-cycle-late ready
        applyStimulus("mem_fast", OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 1'b1, E_NONE, 32'h0);
        applyStimulus("mem_w0", OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 1'b0, E_MEM, 32'h0);
        applyStimulus("mem_w1", OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 1'b1, E_MEM, 32'h0);
        idleCycle("mem_done", E_NONE);

        // Memory wait of 4 with a redirect latched on wait cycle 2
        applyStimulus("mw_c0", OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 1'b0, E_MEM, 32'h0);
        applyStimulus("mw_c1", OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 1'b0, E_MEM, 32'h0);
        applyStimulus("mw_c2_br", OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 32'h400, 1'b1, 1'b0, E_MEM, 32'h0);
        applyStimulus("mw_c3", OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 1'b0, E_MEM, 32'h0);
        applyStimulus("mw_c4_rdy", OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 1'b1, E_MEM, 32'h0);
        idleCycle("mw_pulse", E_FPULS);
        sb_q[$].pc = 32'h400;
        idleCycle("mw_flush2", E_FLUSH);
        idleCycle("mw_done", E_NONE);

        // Timeout after 8 wait cycles, with a pending redirect dropped by reset
        applyStimulus("to_c0", OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 1'b0, E_MEM, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus($sformatf("to_c%0d", i), OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0,
                          (i == 3), 32'h500, 1'b1, 1'b0, E_MEM, 32'h0);
        end
        applyStimulus("to_set", OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 1'b0, E_MEMTO, 32'h0);
        applyStimulus("to_sticky", OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 1'b0, E_MEMTO, 32'h0);
        pulseReset();
        idleCycle("to_cleared", E_NONE);
        applyStimulus("to_run_w0", OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 1'b0, E_MEM, 32'h0);
        applyStimulus("to_run_w1", OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 1'b1, E_MEM, 32'h0);
        idleCycle("to_no_pending", E_NONE);

        // Performance counters: 3 load-use stalls and 2 redirects from reset
        pulseReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus("pf_lu", OP_RTYPE, 4'd7, 4'd2, 1'b1, 1'b1, 4'd7, 1'b0, 32'h0, 1'b0, 1'b0, E_LU, 32'h0);
            applyStimulus("pf_bub", OP_RTYPE, 4'd7, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0, 1'b0, E_NONE, 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus("pf_rd", OP_RTYPE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 32'h600 + 32'(i), 1'b0, 1'b0,
                          E_RDIR, 32'h600 + 32'(i));
            idleCycle("pf_fl", E_FLUSH);
            idleCycle("pf_run", E_NONE);
        end
        @(posedge clk);
        #1;
        checkOutput("perf_stall_cycles", perf_stall_cycles, EXP_STALLS);
        checkOutput("perf_flush_events", perf_flush_events, EXP_FLUSHES);

        @(negedge clk);
        #1;
        checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule
